// File: rtl/mips8_pkg.sv
// Shared definitions for the 8-bit multicycle MIPS datapath: widths,
// next-PC select encodings and instruction field positions.
package mips8_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int IR_BYTES  = 4;

  typedef enum logic [1:0] {
    PCSRC_ALURES = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_RSVD   = 2'd3
  } pcsrc_e;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  function automatic logic multi_hot(input logic [IR_BYTES-1:0] v);
    return $countones(v) > 1;
  endfunction
endpackage

// File: rtl/fetch_datapath_if.sv
// Controller-facing bus of the fetch datapath: control inputs, memory/ALU
// operands in, address, PC, instruction fields and status out.
interface fetch_datapath_if #(parameter int WIDTH = mips8_pkg::WIDTH_DEF);
  import mips8_pkg::*;

  logic [WIDTH-1:0]    memdata;
  logic [WIDTH-1:0]    aluresult;
  logic [WIDTH-1:0]    aluout;
  logic                pcen;
  logic                iord;
  logic [IR_BYTES-1:0] irwrite;
  logic [1:0]          pcsource;
  logic                memread;

  logic [WIDTH-1:0]    adr;
  logic [WIDTH-1:0]    pc;
  logic [31:0]         instr;
  logic [5:0]          op;
  logic [5:0]          funct;
  logic [4:0]          rs;
  logic [4:0]          rt;
  logic [4:0]          rd;
  logic [WIDTH-1:0]    imm;
  logic [WIDTH-1:0]    mdr;
  logic                ir_valid;
  logic                ctl_err;

  modport master (
    output memdata, aluresult, aluout, pcen, iord, irwrite, pcsource, memread,
    input  adr, pc, instr, op, funct, rs, rt, rd, imm, mdr, ir_valid, ctl_err
  );

  modport slave (
    input  memdata, aluresult, aluout, pcen, iord, irwrite, pcsource, memread,
    output adr, pc, instr, op, funct, rs, rt, rd, imm, mdr, ir_valid, ctl_err
  );
endinterface

// File: rtl/fetch_datapath_en_reg.sv
// Enabled register with asynchronous active-low clear to a fixed value.
module en_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb data_d = en ? d : data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data_q <= RST_VAL;
    else        data_q <= data_d;
  end

  assign q = data_q;
endmodule

// File: rtl/fetch_datapath.sv
// Fetch front end: PC, byte-assembled IR with load tracking, MDR, address mux
// and instruction field decode, plus a sticky illegal-control flag.
module fetch_datapath
  import mips8_pkg::*;
#(
  parameter int               WIDTH    = WIDTH_DEF,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input logic             clk,
  input logic             reset,
  fetch_datapath_if.slave bus
);
  logic [WIDTH-1:0]      pc_d;
  logic [WIDTH-1:0]      pc_w;
  logic                  pc_en;
  logic [WIDTH-1:0]      mdr_w;
  logic [IR_BYTES*8-1:0] instr_w;

  logic [IR_BYTES-1:0]   mask_d, mask_q;
  logic                  ir_valid_d, ir_valid_q;
  logic                  ctl_err_d, ctl_err_q;

  always_comb begin
    pc_en = 1'b0;
    pc_d  = bus.aluresult;
    if (bus.pcen) begin
      case (pcsrc_e'(bus.pcsource))
        PCSRC_ALURES: begin pc_en = 1'b1; pc_d = bus.aluresult; end
        PCSRC_ALUOUT: begin pc_en = 1'b1; pc_d = bus.aluout; end
        PCSRC_JUMP:   begin pc_en = 1'b1; pc_d = {instr_w[WIDTH-3:0], 2'b00}; end
        PCSRC_RSVD:   pc_en = 1'b0;
        default:      pc_en = 1'b0;
      endcase
    end
  end

  en_reg #(.W(WIDTH), .RST_VAL(PC_RESET)) u_pc (
    .clk(clk), .reset(reset), .en(pc_en), .d(pc_d), .q(pc_w)
  );

  en_reg #(.W(WIDTH), .RST_VAL('0)) u_mdr (
    .clk(clk), .reset(reset), .en(bus.memread), .d(bus.memdata), .q(mdr_w)
  );

  for (genvar k = 0; k < IR_BYTES; k++) begin : g_ir
    en_reg #(.W(8), .RST_VAL(8'h00)) u_ir_byte (
      .clk(clk), .reset(reset), .en(bus.irwrite[k]),
      .d(bus.memdata[7:0]), .q(instr_w[8*k +: 8])
    );
  end

  // Byte 0 marks the start of a fetch; later bytes accumulate into the mask.
  always_comb begin
    mask_d     = bus.irwrite[0] ? bus.irwrite : (mask_q | bus.irwrite);
    ir_valid_d = (mask_d == '1);
    ctl_err_d  = ctl_err_q;
    if (bus.pcen && (pcsrc_e'(bus.pcsource) == PCSRC_RSVD)) ctl_err_d = 1'b1;
    if (multi_hot(bus.irwrite))                            ctl_err_d = 1'b1;
    if (|(bus.irwrite[IR_BYTES-1:1] & mask_q[IR_BYTES-1:1])) ctl_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q     <= '0;
      ir_valid_q <= 1'b0;
      ctl_err_q  <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      ir_valid_q <= ir_valid_d;
      ctl_err_q  <= ctl_err_d;
    end
  end

  assign bus.adr      = bus.iord ? bus.aluout : pc_w;
  assign bus.pc       = pc_w;
  assign bus.instr    = instr_w;
  assign bus.op       = instr_w[OP_MSB:OP_LSB];
  assign bus.rs       = instr_w[RS_MSB:RS_LSB];
  assign bus.rt       = instr_w[RT_MSB:RT_LSB];
  assign bus.rd       = instr_w[RD_MSB:RD_LSB];
  assign bus.funct    = instr_w[FUNCT_MSB:FUNCT_LSB];
  assign bus.imm      = instr_w[WIDTH-1:0];
  assign bus.mdr      = mdr_w;
  assign bus.ir_valid = ir_valid_q;
  assign bus.ctl_err  = ctl_err_q;
endmodule

// File: tb/tb_fetch_datapath.sv
// Bench for fetch_datapath: directed vector table, corner sequences and a
// randomized run against a byte-level reference model.
module tb_fetch_datapath;
  import mips8_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_datapath_if #(.WIDTH(W)) bus();

  fetch_datapath #(.WIDTH(W), .PC_RESET(8'h00)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] m_pc;
  logic [7:0] m_ir [4];
  logic [7:0] m_mdr;
  logic       m_loaded [4];
  logic       m_err;

  typedef struct {
    logic [3:0]  irwrite;
    logic [7:0]  memdata;
    logic        pcen;
    logic [1:0]  pcsource;
    logic [7:0]  aluout;
    logic [7:0]  aluresult;
    logic        memread;
    logic [31:0] e_instr;
    logic [7:0]  e_pc;
    logic [7:0]  e_mdr;
    logic        e_valid;
    logic        e_err;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] irw, input logic [7:0] md, input logic pcen,
                       input logic [1:0] ps, input logic [7:0] ao, input logic [7:0] ar,
                       input logic iord, input logic mr);
    bus.irwrite   = irw;
    bus.memdata   = md;
    bus.pcen      = pcen;
    bus.pcsource  = ps;
    bus.aluout    = ao;
    bus.aluresult = ar;
    bus.iord      = iord;
    bus.memread   = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] ei, input logic [7:0] ep,
                             input logic [7:0] em, input logic ev, input logic ee);
    chk({tag, "_instr"}, bus.instr, ei);
    chk({tag, "_pc"}, {24'h0, bus.pc}, {24'h0, ep});
    chk({tag, "_mdr"}, {24'h0, bus.mdr}, {24'h0, em});
    chk({tag, "_valid"}, {31'h0, bus.ir_valid}, {31'h0, ev});
    chk({tag, "_err"}, {31'h0, bus.ctl_err}, {31'h0, ee});
    chk({tag, "_op"}, {26'h0, bus.op}, {26'h0, ei[31:26]});
    chk({tag, "_rs"}, {27'h0, bus.rs}, {27'h0, ei[25:21]});
    chk({tag, "_rt"}, {27'h0, bus.rt}, {27'h0, ei[20:16]});
    chk({tag, "_rd"}, {27'h0, bus.rd}, {27'h0, ei[15:11]});
    chk({tag, "_funct"}, {26'h0, bus.funct}, {26'h0, ei[5:0]});
    chk({tag, "_imm"}, {24'h0, bus.imm}, {24'h0, ei[7:0]});
  endtask

  task automatic model_reset();
    m_pc  = 8'h00;
    m_mdr = 8'h00;
    m_err = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_ir[k]     = 8'h00;
      m_loaded[k] = 1'b0;
    end
  endtask

  // Applies the current bus inputs to the model as one clock edge.
  task automatic model_step();
    int nsel;
    logic [7:0] target;
    nsel = 0;
    if (bus.pcen) begin
      if (bus.pcsource == 2'd0) m_pc = bus.aluresult;
      else if (bus.pcsource == 2'd1) m_pc = bus.aluout;
      else if (bus.pcsource == 2'd2) begin
        target = m_ir[0] * 4;
        m_pc = target;
      end else m_err = 1'b1;
    end
    for (int k = 0; k < 4; k++) if (bus.irwrite[k]) nsel++;
    if (nsel > 1) m_err = 1'b1;
    for (int k = 1; k < 4; k++) if (bus.irwrite[k] && m_loaded[k]) m_err = 1'b1;
    if (bus.irwrite[0]) for (int k = 0; k < 4; k++) m_loaded[k] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.irwrite[k]) begin
        m_ir[k]     = bus.memdata;
        m_loaded[k] = 1'b1;
      end
    end
    if (bus.memread) m_mdr = bus.memdata;
  endtask

  task automatic check_model(input string tag);
    logic all_loaded;
    all_loaded = m_loaded[0] && m_loaded[1] && m_loaded[2] && m_loaded[3];
    check_state(tag, {m_ir[3], m_ir[2], m_ir[1], m_ir[0]}, m_pc, m_mdr, all_loaded, m_err);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    reset = 1'b0;
    drive(4'h0, 8'h00, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset held with random activity on every input
    for (int i = 0; i < 4; i++) begin
      drive(4'($urandom), 8'($urandom), 1'($urandom), 2'($urandom), 8'($urandom),
            8'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    check_state("rst_hold", 32'h0, 8'h00, 8'h00, 1'b0, 1'b0);

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(4'h0, 8'($urandom), 1'b0, 2'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
      tick();
    end
    check_state("rst_release", 32'h0, 8'h00, 8'h00, 1'b0, 1'b0);

    tbl[0] = '{4'h1, 8'h04, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 32'h00000004, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{4'h2, 8'h00, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 32'h00000004, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{4'h4, 8'h22, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 32'h00220004, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{4'h8, 8'h8C, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 32'h8C220004, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{4'h1, 8'h08, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 32'h8C220008, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{4'h0, 8'h00, 1'b1, 2'd1, 8'h3C, 8'h00, 1'b0, 32'h8C220008, 8'h3C, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{4'h0, 8'h00, 1'b0, 2'd1, 8'h77, 8'h55, 1'b0, 32'h8C220008, 8'h3C, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{4'h0, 8'h5A, 1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 32'h8C220008, 8'h3C, 8'h5A, 1'b0, 1'b0};
    tbl[8] = '{4'h0, 8'hFF, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 32'h8C220008, 8'h3C, 8'h5A, 1'b0, 1'b0};
    tbl[9] = '{4'h0, 8'h00, 1'b1, 2'd0, 8'h00, 8'h3D, 1'b0, 32'h8C220008, 8'h3D, 8'h5A, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].irwrite, tbl[i].memdata, tbl[i].pcen, tbl[i].pcsource,
            tbl[i].aluout, tbl[i].aluresult, 1'b0, tbl[i].memread);
      tick();
      check_state($sformatf("vec%0d", i), tbl[i].e_instr, tbl[i].e_pc, tbl[i].e_mdr,
                  tbl[i].e_valid, tbl[i].e_err);
      if (i == 3) begin
        chk("lw_op", {26'h0, bus.op}, 32'h23);
        chk("lw_rs", {27'h0, bus.rs}, 32'h1);
        chk("lw_rt", {27'h0, bus.rt}, 32'h2);
        chk("lw_imm", {24'h0, bus.imm}, 32'h04);
      end
    end

    // Jump target, then reserved select sets the sticky error
    do_reset();
    drive(4'h1, 8'h05, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    drive(4'h2, 8'h00, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    drive(4'h4, 8'h00, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    drive(4'h8, 8'h08, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    check_state("j_fetch", 32'h08000005, 8'h00, 8'h00, 1'b1, 1'b0);
    drive(4'h0, 8'h00, 1'b1, 2'd2, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    chk("jump_pc", {24'h0, bus.pc}, 32'h14);
    drive(4'h0, 8'h00, 1'b1, 2'd3, 8'h99, 8'h98, 1'b0, 1'b0); tick();
    chk("rsvd_pc", {24'h0, bus.pc}, 32'h14);
    chk("rsvd_err", {31'h0, bus.ctl_err}, 32'h1);
    drive(4'h0, 8'h00, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("err_sticky", {31'h0, bus.ctl_err}, 32'h1);
    reset = 1'b0;
    #1;
    chk("err_async_clr", {31'h0, bus.ctl_err}, 32'h0);
    reset = 1'b1;
    model_reset();

    // Address mux, combinational
    drive(4'h0, 8'h00, 1'b1, 2'd1, 8'h10, 8'h00, 1'b0, 1'b0); tick();
    chk("pc_set10", {24'h0, bus.pc}, 32'h10);
    drive(4'h0, 8'h00, 1'b0, 2'd0, 8'h40, 8'h00, 1'b1, 1'b0);
    #1;
    chk("adr_aluout", {24'h0, bus.adr}, 32'h40);
    bus.iord = 1'b0;
    #1;
    chk("adr_pc", {24'h0, bus.adr}, 32'h10);

    // Two IR bytes in one cycle
    do_reset();
    drive(4'h3, 8'hAA, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    chk("multi_instr", {16'h0, bus.instr[15:0]}, 32'hAAAA);
    chk("multi_err", {31'h0, bus.ctl_err}, 32'h1);

    // Re-loading a byte already loaded in this fetch
    do_reset();
    drive(4'h1, 8'h11, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    drive(4'h2, 8'h22, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    chk("order_ok_err", {31'h0, bus.ctl_err}, 32'h0);
    drive(4'h2, 8'h33, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    chk("refetch_err", {31'h0, bus.ctl_err}, 32'h1);
    chk("refetch_byte", {24'h0, bus.instr[15:8]}, 32'h33);

    // Reset in the middle of a fetch discards the partial IR immediately
    do_reset();
    drive(4'h1, 8'h5C, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    drive(4'h2, 8'hC3, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    drive(4'h0, 8'h00, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("mid_pre_instr", bus.instr, 32'h0000C35C);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_instr", bus.instr, 32'h0);
    chk("mid_rst_valid", {31'h0, bus.ir_valid}, 32'h0);
    reset = 1'b1;
    model_reset();
    tick();

    // Randomized run against the reference model
    for (int c = 0; c < 400; c++) begin
      int r;
      logic [3:0] irw;
      logic [1:0] ps;
      if (c % 80 == 79) begin
        reset = 1'b0;
        #1;
        model_reset();
        check_model("rand_rst");
        reset = 1'b1;
      end
      r = $urandom_range(0, 9);
      if (r < 4)       irw = 4'h0;
      else if (r < 8)  irw = 4'(1 << $urandom_range(0, 3));
      else if (r == 8) irw = 4'h1;
      else             irw = 4'($urandom_range(0, 15));
      ps = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      drive(irw, 8'($urandom), 1'($urandom_range(0, 3) == 0), ps, 8'($urandom),
            8'($urandom), 1'($urandom), 1'($urandom));
      #1;
      chk("rand_adr", {24'h0, bus.adr}, {24'h0, bus.iord ? bus.aluout : m_pc});
      model_step();
      tick();
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
